idma_tpram_fifo_ctrl: RTL and testbench

//  - Single-clock valid/ready FIFO controller wrapped around one 64x144 two-port SRAM macro, in the iDMA/iNoC datapath.
//  - Upstream writes into the SRAM; the block drives the macro's read/write strobes and absorbs its 1-cycle read latency.
//  - A 2-entry output buffer gives a registered, show-ahead, full-throughput (1 beat/clk) downstream interface.

---
 rtl/idma_tpram_fifo_ctrl_if.sv | 22 ++
 rtl/idma_tpram_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_idma_tpram_fifo_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idma_tpram_fifo_ctrl_if.sv
// Valid/ready handshake bundle for the TPRAM FIFO controller: upstream write port and
// downstream show-ahead read port.
interface idma_tpram_fifo_ctrl_if #(
  parameter int unsigned DW = 144
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/idma_tpram_fifo_ctrl.sv
// FIFO controller around a 1-cycle-latency two-port SRAM with a 2-entry registered output buffer.
// Optional almost_full watermark output is enabled by defining IDMA_FIFO_WMARK_EN.
module idma_tpram_fifo_ctrl #(
  parameter int unsigned DW     = 144,
  parameter int unsigned AW     = 6,
`ifdef IDMA_FIFO_WMARK_EN
  parameter int unsigned AF_LVL = 60,
`endif
  parameter int unsigned DEPTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  idma_tpram_fifo_ctrl_if.slave  bus,
  output logic [AW:0]            fill_cnt,
  output logic                   ram_wceb,
  output logic [AW-1:0]          ram_waddr,
  output logic [DW-1:0]          ram_wdata,
  output logic                   ram_rceb,
  output logic [AW-1:0]          ram_raddr,
  input  logic [DW-1:0]          ram_rdata
`ifdef IDMA_FIFO_WMARK_EN
  ,
  output logic                   almost_full
`endif
);

  localparam logic [AW:0] Full = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d, ob_after;
  logic [DW-1:0] ob0_q, ob0_d, ob1_q, ob1_d;
  logic [2:0]    buf_lvl;
  logic          wr, pop, issue;

  assign bus.in_ready  = (ram_cnt_q != Full);
  assign bus.out_valid = (ob_cnt_q != 2'd0);
  assign bus.out_data  = ob0_q;
  assign ram_wceb      = ~wr;
  assign ram_waddr     = wptr_q;
  assign ram_wdata     = bus.in_data;
  assign ram_rceb      = ~issue;
  assign ram_raddr     = rptr_q;
  assign fill_cnt      = ram_cnt_q + (AW+1)'(inflight_q) + (AW+1)'(ob_cnt_q);

  always_comb begin
    wr      = bus.in_valid & bus.in_ready & ~flush;
    pop     = bus.out_valid & bus.out_ready & ~flush;
    // Slots the buffer will need after this clk's pop, counting the read already in flight.
    buf_lvl = 3'(ob_cnt_q) + 3'(inflight_q) - 3'(pop);
    issue   = ~flush & (ram_cnt_q != '0) & (buf_lvl < 3'd2);
  end

  always_comb begin
    wptr_d     = wptr_q + AW'(wr);
    rptr_d     = rptr_q + AW'(issue);
    ram_cnt_d  = ram_cnt_q + (AW+1)'(wr) - (AW+1)'(issue);
    inflight_d = issue;
    ob_after   = ob_cnt_q - 2'(pop);
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    if (pop && ob_cnt_q == 2'd2) begin
      ob0_d = ob1_q;
    end
    if (inflight_q) begin
      if (ob_after == 2'd0) begin
        ob0_d = ram_rdata;
      end else begin
        ob1_d = ram_rdata;
      end
    end
    ob_cnt_d = ob_after + 2'(inflight_q);
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      ob_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= '0;
      ob0_q      <= '0;
      ob1_q      <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
    end
  end

`ifdef IDMA_FIFO_WMARK_EN
  logic [AW:0] fill_cnt_d;
  assign fill_cnt_d = ram_cnt_d + (AW+1)'(inflight_d) + (AW+1)'(ob_cnt_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (fill_cnt_d >= (AW+1)'(AF_LVL));
    end
  end
`endif

endmodule

// File: tb/tb_idma_tpram_fifo_ctrl.sv
// Self-checking bench for idma_tpram_fifo_ctrl with a behavioural 1-cycle-latency SRAM model.
module tb_idma_tpram_fifo_ctrl;
  localparam int unsigned DW = 144;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [AW:0]   fill_cnt;
  logic          ram_wceb, ram_rceb;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] mem [64];
`ifdef IDMA_FIFO_WMARK_EN
  logic          almost_full;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  idma_tpram_fifo_ctrl_if #(.DW(DW)) bus ();

  idma_tpram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .fill_cnt  (fill_cnt),
    .ram_wceb  (ram_wceb),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_rceb  (ram_rceb),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
`ifdef IDMA_FIFO_WMARK_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_wceb) mem[ram_waddr] <= ram_wdata;
    if (!ram_rceb) ram_rdata <= mem[ram_raddr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [6:0] e_fill;
    logic       e_wceb;
    logic       e_rceb;
  } vec_t;

  vec_t vecs [7];
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_d;

  initial begin
    int acc, got, s, r, bubbles, mdl_fill;
    bit started, w63, r63, wwrap, rwrap, seen;

    // in_valid, in_data, out_ready | in_ready, out_valid, out_data, fill, wceb, rceb
    vecs[0] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h00, 7'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 8'h00, 7'd2, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 7'd3, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 7'd2, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 7'd1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0, 1'b1, 1'b1};

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", DW'(bus.in_ready), DW'(1));
    chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_fill", DW'(fill_cnt), DW'(0));
    chk("rst_wceb", DW'(ram_wceb), DW'(1));
    chk("rst_rceb", DW'(ram_rceb), DW'(1));
`ifdef IDMA_FIFO_WMARK_EN
    chk("rst_af", DW'(almost_full), DW'(0));
`endif
    @(negedge clk); rst = 1'b0;

    // Basic latency and ordering table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.in_valid = vecs[i].iv; bus.in_data = DW'(vecs[i].id); bus.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("t1_in_ready[%0d]", i), DW'(bus.in_ready), DW'(vecs[i].e_ir));
      chk($sformatf("t1_out_valid[%0d]", i), DW'(bus.out_valid), DW'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("t1_out_data[%0d]", i), bus.out_data, DW'(vecs[i].e_od));
      chk($sformatf("t1_fill[%0d]", i), DW'(fill_cnt), DW'(vecs[i].e_fill));
      chk($sformatf("t1_wceb[%0d]", i), DW'(ram_wceb), DW'(vecs[i].e_wceb));
      chk($sformatf("t1_rceb[%0d]", i), DW'(ram_rceb), DW'(vecs[i].e_rceb));
    end

    // Fill to capacity with downstream stalled, then drain
    acc = 0;
    for (int c = 0; c < 120 && acc < 67; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = DW'(100 + acc); bus.out_ready = 1'b0;
      #1;
      if (bus.in_ready) acc++;
    end
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_accepted", DW'(acc), DW'(66));
    chk("t2_in_ready", DW'(bus.in_ready), DW'(0));
    chk("t2_fill", DW'(fill_cnt), DW'(66));
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 300 && got < 66; c++) begin
      #1;
      if (bus.out_valid) begin
        chk("t2_data", bus.out_data, DW'(100 + got));
        got++;
      end
      @(negedge clk);
    end
    chk("t2_popped", DW'(got), DW'(66));
    chk("t2_fill_empty", DW'(fill_cnt), DW'(0));
    chk("t2_out_valid_empty", DW'(bus.out_valid), DW'(0));

    // Continuous streaming across pointer wrap
    s = 0; r = 0; bubbles = 0; started = 0; w63 = 0; r63 = 0; wwrap = 0; rwrap = 0;
    for (int c = 0; c < 400 && r < 200; c++) begin
      @(negedge clk);
      bus.in_valid = (s < 200); bus.in_data = DW'(1000 + s); bus.out_ready = 1'b1;
      #1;
      if (bus.in_valid && bus.in_ready) s++;
      if (!ram_wceb) begin
        if (w63 && ram_waddr == 6'd0) wwrap = 1;
        w63 = (ram_waddr == 6'd63);
      end
      if (!ram_rceb) begin
        if (r63 && ram_raddr == 6'd0) rwrap = 1;
        r63 = (ram_raddr == 6'd63);
      end
      if (bus.out_valid) begin
        started = 1;
        chk("t3_data", bus.out_data, DW'(1000 + r));
        r++;
      end else if (started) begin
        bubbles++;
      end
    end
    chk("t3_received", DW'(r), DW'(200));
    chk("t3_bubbles", DW'(bubbles), DW'(0));
    chk("t3_waddr_wrap", DW'(wwrap), DW'(1));
    chk("t3_raddr_wrap", DW'(rwrap), DW'(1));

    // Random traffic against a queue scoreboard
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    mdl_fill = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      chk("t4_fill", DW'(fill_cnt), DW'(mdl_fill));
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("t4_pop_on_empty", DW'(bus.out_valid), DW'(0));
        end else begin
          exp_d = q.pop_front();
          chk("t4_data", bus.out_data, exp_d);
        end
        mdl_fill--;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(bus.in_data);
        mdl_fill++;
      end
    end
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      #1;
      if (bus.out_valid) begin
        exp_d = q.pop_front();
        chk("t4_drain_data", bus.out_data, exp_d);
      end
      @(negedge clk);
    end
    chk("t4_drain_left", DW'(q.size()), DW'(0));
    chk("t4_drain_fill", DW'(fill_cnt), DW'(0));

    // Flush while a read is in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(8'h50 + i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_fill5", DW'(fill_cnt), DW'(5));
    bus.out_ready = 1'b1;
    #1;
    chk("t5_read_issue", DW'(ram_rceb), DW'(0));
    @(negedge clk);
    bus.out_ready = 1'b0; flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = DW'(8'hBB);
    #1;
    chk("t5_flush_no_read", DW'(ram_rceb), DW'(1));
    chk("t5_flush_no_write", DW'(ram_wceb), DW'(1));
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("t5_fill_after_flush", DW'(fill_cnt), DW'(0));
    chk("t5_out_valid_after_flush", DW'(bus.out_valid), DW'(0));
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = DW'(8'hAA);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (bus.out_valid) begin
        seen = 1;
        chk("t5_first_after_flush", bus.out_data, DW'(8'hAA));
      end
      @(negedge clk);
    end
    chk("t5_aa_seen", DW'(seen), DW'(1));
    repeat (3) @(negedge clk);
    chk("t5_no_stale", DW'(bus.out_valid), DW'(0));
    chk("t5_fill_end", DW'(fill_cnt), DW'(0));
    bus.out_ready = 1'b0;

`ifdef IDMA_FIFO_WMARK_EN
    // Watermark threshold crossing
    for (int i = 0; i < 59; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_fill59", DW'(fill_cnt), DW'(59));
    chk("t6_af_at59", DW'(almost_full), DW'(0));
    bus.in_valid = 1'b1; bus.in_data = DW'(59);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_fill60", DW'(fill_cnt), DW'(60));
    chk("t6_af_at60", DW'(almost_full), DW'(1));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t6_fill_back59", DW'(fill_cnt), DW'(59));
    chk("t6_af_back59", DW'(almost_full), DW'(0));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
`endif

    // Asynchronous reset in the middle of a transfer
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(8'h70 + i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t7_async_fill", DW'(fill_cnt), DW'(0));
    chk("t7_async_out_valid", DW'(bus.out_valid), DW'(0));
    chk("t7_async_out_data", bus.out_data, '0);
    @(negedge clk); rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
